uart_cpld_bridge: RTL and testbench
===================================

// Module: uart_cpld_bridge
// PURPOSE
//  Device-side responder for the CPU's parallel UART strobe interface (rdn/wrn, tbre/tsre/data_ready).
//  Sits between the shared 8-bit data bus and the serial pins (txd/rxd); emulates the board CPLD UART.
//  Holds one TX holding byte, one TX shift byte and one RX byte; runs 8N1 framing at a fixed baud.
//  Strobes are sampled in this block's clock domain, which runs at >= 4x the CPU clock.
// PARAMETERS
//  CLK_FREQ  50_000_000  frequency of clk in Hz
//  BAUD      115200      serial bit rate; DIV = CLK_FREQ/BAUD (integer, >= 4) clocks per bit
// PORTS
//  clk         in   1  bridge clock, all logic on posedge
//  rst         in   1  synchronous reset, active-high
//  bus_data_i  in   8  data bus [7:0] as driven by the CPU during a write strobe
//  bus_data_o  out  8  RX byte presented to the data bus
//  bus_data_oe out  1  tri-state enable for bus_data_o (1 = drive the bus)
//  rdn         in   1  read strobe from CPU, active-low, asynchronous to clk
//  wrn         in   1  write strobe from CPU, active-low, asynchronous to clk
//  tbre        out  1  TX holding register empty (1 = a write is accepted)
//  tsre        out  1  TX shift register empty (1 = line idle, no frame in flight)
//  data_ready  out  1  RX byte valid and not yet read
//  overrun     out  1  sticky: an RX byte arrived while data_ready=1; cleared by a read
//  txd         out  1  serial transmit, idle high
//  rxd         in   1  serial receive, asynchronous
// BEHAVIOUR
//  Reset: txd=1, tbre=1, tsre=1, data_ready=0, overrun=0, bus_data_o=0, bus_data_oe=0; both FSMs go to IDLE.
//  Strobe sync: rdn, wrn and rxd each go through a 2-flop synchronizer with reset value 1.
//   A strobe event is a synchronized 1->0 (fall) or 0->1 (rise) transition. The CPU must hold a strobe low >= 2 clk.
//  Write: on a wrn fall, if tbre=1, latch bus_data_i into the holding register and set tbre=0.
//   If tbre=0, the write is dropped and no state changes. The CPU must poll tbre first.
//  Read: bus_data_oe = ~rdn (raw, combinational) so data is valid within the CPU's half-cycle.
//   bus_data_o holds the RX byte. On a synchronized rdn rise: data_ready<=0 and overrun<=0.
//  TX FSM (IDLE,START,DATA,STOP), bit counter 0..DIV-1, 3-bit index:
//   IDLE: if tbre=0, load shifter<=holding, tbre<=1, tsre<=0, txd<=0, go to START.
//    The holding register refills while the frame shifts.
//   START: hold txd=0 for DIV clk, then go to DATA.
//   DATA: drive 8 bits LSB-first, DIV clk each, then go to STOP.
//   STOP: txd=1 for DIV clk. If tbre=0 at exit, start the next frame back-to-back with no idle gap.
//    Otherwise tsre<=1 and go to IDLE.
//  RX FSM (IDLE,START,DATA,STOP), on synchronized rxd:
//   IDLE: a fall goes to START.
//   START: at DIV/2 re-sample. If low, go to DATA. If high (glitch), go back to IDLE.
//   DATA: sample every DIV clk, LSB-first, 8 bits.
//   STOP: after DIV clk, sample. If high, load RX byte, data_ready<=1, and set overrun<=1 if data_ready was already 1.
//    The new byte overwrites the old one. If low (framing error), discard the byte and keep flags.
//    Return to IDLE only once rxd is high.
//  Simultaneous events:
//   An RX load and an rdn rise in the same clk: the load wins, so data_ready=1 and overrun=0.
//   A wrn fall while the TX FSM takes the holding byte in the same clk: the write is rejected, because tbre is still 0 that cycle.
//  Reset mid-frame aborts both frames immediately (txd=1 next clk) and drops any buffered bytes.
//  Counters are sized clog2(DIV); no arithmetic overflow is possible.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000, DIV=10)
//  Reset -> txd=1, tbre=1, tsre=1, data_ready=0, bus_data_oe=0.
//  Write 0xA5 (wrn low 4 clk) -> tbre falls within 3 clk, then rises when the frame starts, tsre=0.
//   txd shows 0,1,0,1,0,0,1,0,1,1 at 10 clk/bit. tsre=1 after 100 clk.
//  Two writes 0x55 then 0x0F (second after tbre=1) -> two back-to-back frames with no idle gap.
//   A third write while tbre=0 is dropped.
//  Drive an rxd frame for 0x3C -> data_ready=1 after the stop sample.
//   rdn low drives bus_data_o=0x3C with bus_data_oe=1. After rdn high, data_ready=0.
//  Receive 0x11 then 0x22 without reading -> overrun=1 and the byte reads 0x22.
//   A 3-clk low glitch on rxd receives nothing. A stop bit held low discards the byte.
//  Assert rst for 1 clk mid-TX-frame and mid-RX-frame -> outputs return to reset values next clk.
//   The next frame then transmits correctly.

Source files
------------

// File: rtl/uart_cpld_bridge.sv
// CPLD-style UART bridge: CPU strobe interface (rdn/wrn, tbre/tsre/data_ready) to 8N1 serial pins.
// One TX holding byte, one TX shift byte, one RX byte; all logic in the clk domain.
module uart_cpld_bridge #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_data_i,
  output logic [7:0] bus_data_o,
  output logic       bus_data_oe,
  input  logic       rdn,
  input  logic       wrn,
  output logic       tbre,
  output logic       tsre,
  output logic       data_ready,
  output logic       overrun,
  output logic       txd,
  input  logic       rxd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // [1] is the synchronized level, [2] its previous value for edge detection
  logic [2:0] rdn_sr, wrn_sr, rxd_sr;
  logic       rd_rise, wr_fall, rx_fall, rxd_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdn_sr <= 3'b111;
      wrn_sr <= 3'b111;
      rxd_sr <= 3'b111;
    end else begin
      rdn_sr <= {rdn_sr[1:0], rdn};
      wrn_sr <= {wrn_sr[1:0], wrn};
      rxd_sr <= {rxd_sr[1:0], rxd};
    end
  end

  assign rd_rise = ~rdn_sr[2] & rdn_sr[1];
  assign wr_fall = wrn_sr[2] & ~wrn_sr[1];
  assign rx_fall = rxd_sr[2] & ~rxd_sr[1];
  assign rxd_s   = rxd_sr[1];

  assign bus_data_oe = ~rdn;

  // ---------------- TX ----------------
  tx_state_t       tx_state, tx_next;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_idx;
  logic [7:0]      tx_hold, tx_shift;
  logic            tx_load, tx_bit_end;

  assign tx_bit_end = (tx_cnt == LAST);

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!tbre) begin tx_load = 1'b1; tx_next = TX_START; end
      TX_START: if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:
        if (tx_bit_end) begin
          // pending holding byte chains straight into the next start bit
          if (!tbre) begin tx_load = 1'b1; tx_next = TX_START; end
          else tx_next = TX_IDLE;
        end
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_hold  <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
      tsre     <= 1'b1;
      tbre     <= 1'b1;
    end else begin
      if (tx_load) begin
        tx_shift <= tx_hold;
        tx_cnt   <= '0;
        tx_idx   <= '0;
        txd      <= 1'b0;
        tsre     <= 1'b0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_bit_end) begin
          tx_cnt <= '0;
          case (tx_state)
            TX_START: begin
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
            TX_DATA:
              if (tx_idx == 3'd7) txd <= 1'b1;
              else begin
                txd      <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_idx   <= tx_idx + 3'd1;
              end
            TX_STOP: tsre <= 1'b1;
            default: ;
          endcase
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
      // tbre is still 0 in the load cycle, so a coincident write is rejected
      if (tx_load) tbre <= 1'b1;
      else if (wr_fall && tbre) begin
        tbre    <= 1'b0;
        tx_hold <= bus_data_i;
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_idx;
  logic [7:0]      rx_shift, rx_byte;
  logic            rx_ferr, rx_load, rx_bit_end, rx_half;

  assign rx_bit_end = (rx_cnt == LAST);
  assign rx_half    = (rx_cnt == HALF);

  always_comb begin
    rx_next = rx_state;
    rx_load = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:
        // after a framing error, wait for the line to return high
        if (rx_ferr) begin
          if (rxd_s) rx_next = RX_IDLE;
        end else if (rx_bit_end && rxd_s) begin
          rx_load = 1'b1;
          rx_next = RX_IDLE;
        end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_ferr    <= 1'b0;
      rx_byte    <= '0;
      data_ready <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt  <= '0;
          rx_idx  <= '0;
          rx_ferr <= 1'b0;
        end
        RX_START:
          if (rx_half) rx_cnt <= '0;
          else         rx_cnt <= rx_cnt + CW'(1);
        RX_DATA:
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        RX_STOP:
          if (!rx_ferr) begin
            if (rx_bit_end) begin
              if (!rxd_s) rx_ferr <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + CW'(1);
            end
          end
        default: ;
      endcase
      // a load beats a coincident read-release
      if (rx_load) begin
        rx_byte    <= rx_shift;
        data_ready <= 1'b1;
        overrun    <= rd_rise ? 1'b0 : (overrun | data_ready);
      end else if (rd_rise) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

  assign bus_data_o = rx_byte;

endmodule

// File: tb/tb_uart_cpld_bridge.sv
// Self-checking bench for uart_cpld_bridge at DIV=10: directed corners plus randomized TX/RX traffic
// against a frame-level reference model.
module tb_uart_cpld_bridge;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_data_i, bus_data_o;
  logic       bus_data_oe, rdn, wrn, tbre, tsre, data_ready, overrun, txd, rxd;

  int checks = 0;
  int errors = 0;

  // reference RX state
  logic [7:0] m_byte;
  logic       m_dr, m_ov;

  uart_cpld_bridge #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .bus_data_i(bus_data_i), .bus_data_o(bus_data_o),
    .bus_data_oe(bus_data_oe), .rdn(rdn), .wrn(wrn), .tbre(tbre), .tsre(tsre),
    .data_ready(data_ready), .overrun(overrun), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // all tasks start and end just after a negedge
  task automatic wr_byte(input logic [7:0] b);
    bus_data_i = b;
    wrn = 1'b0;
    repeat (4) @(negedge clk);
    wrn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_byte(input logic [7:0] exp);
    rdn = 1'b0;
    @(negedge clk);
    chk("rd_oe", bus_data_oe, 1);
    chk("rd_data", bus_data_o, exp);
    repeat (3) @(negedge clk);
    rdn = 1'b1;
    #1 chk("rd_oe_off", bus_data_oe, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tbre();
    int w = 0;
    while (!tbre && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("tbre_wait", tbre, 1);
  endtask

  // expects a whole frame of b; budget = idle clocks tolerated before the start bit
  task automatic tx_mon(input logic [7:0] b, input int budget);
    int w = 0;
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(negedge clk);
    while (txd !== 1'b0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (txd !== 1'b0) begin
      chk("tx_start_timeout", txd, 0);
      return;
    end
    chk("tsre_busy", tsre, 0);
    for (int i = 0; i < 10 * DIV; i++) begin
      if (i > 0) @(negedge clk);
      chk("txd_bit", txd, fr[i / DIV]);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop, input int extra);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (DIV) @(negedge clk);
    end
    repeat (extra) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic idle_tx(input string tag);
    int low = 0;
    repeat (20) begin
      @(negedge clk);
      if (!txd) low++;
    end
    chk(tag, low, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, r;
    logic       sb;
    rst = 1'b1; wrn = 1'b1; rdn = 1'b1; rxd = 1'b1; bus_data_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_tbre", tbre, 1);
    chk("rst_tsre", tsre, 1);
    chk("rst_dr", data_ready, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_oe", bus_data_oe, 0);
    chk("rst_data", bus_data_o, 0);

    // single frame 0xA5
    fork
      wr_byte(8'hA5);
      tx_mon(8'hA5, 20);
      begin
        logic seen = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (!tbre) seen = 1'b1;
        end
        chk("tbre_fall", seen, 1);
      end
    join
    @(negedge clk);
    chk("tsre_done", tsre, 1);
    chk("tbre_done", tbre, 1);

    // back-to-back frames, third write dropped
    fork
      begin
        wr_byte(8'h55);
        wait_tbre();
        wr_byte(8'h0F);
        repeat (5) @(negedge clk);
        chk("tbre_full", tbre, 0);
        wr_byte(8'h99);
      end
      begin
        tx_mon(8'h55, 20);
        tx_mon(8'h0F, 0);
        idle_tx("no_third_frame");
        chk("tsre_idle", tsre, 1);
      end
    join

    // RX 0x3C and read
    rx_send(8'h3C, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("rx_dr", data_ready, 1);
    chk("rx_ov", overrun, 0);
    rd_byte(8'h3C);
    chk("rd_clr_dr", data_ready, 0);

    // overrun
    rx_send(8'h11, 1'b1, 0);
    rx_send(8'h22, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("ovr_dr", data_ready, 1);
    chk("ovr_ov", overrun, 1);
    rd_byte(8'h22);
    chk("ovr_clr_dr", data_ready, 0);
    chk("ovr_clr_ov", overrun, 0);

    // glitch and framing error leave a pending byte and flags untouched
    rx_send(8'h5A, 1'b1, 0);
    repeat (3) @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    rx_send(8'h77, 1'b0, 10);
    repeat (5) @(negedge clk);
    chk("ferr_dr", data_ready, 1);
    chk("ferr_ov", overrun, 0);
    rd_byte(8'h5A);

    // load coinciding with read release: load wins, overrun cleared
    rx_send(8'h01, 1'b1, 0);
    rx_send(8'h02, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("pre_sim_ov", overrun, 1);
    fork
      rx_send(8'hE7, 1'b1, 0);
      begin
        repeat (90) @(negedge clk);
        rdn = 1'b0;
        repeat (5) @(negedge clk);
        rdn = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("sim_dr", data_ready, 1);
    chk("sim_ov", overrun, 0);
    rd_byte(8'hE7);

    // randomized concurrent TX/RX against the reference model
    m_dr = 1'b0; m_ov = 1'b0; m_byte = 8'h00;
    for (int it = 0; it < 8; it++) begin
      b  = 8'($urandom);
      r  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      fork
        wr_byte(b);
        tx_mon(b, 20);
        rx_send(r, sb, sb ? 0 : 5);
      join
      if (sb) begin
        if (m_dr) m_ov = 1'b1;
        m_byte = r;
        m_dr   = 1'b1;
      end
      repeat (3) @(negedge clk);
      chk("rnd_dr", data_ready, m_dr);
      chk("rnd_ov", overrun, m_ov);
      if (m_dr && $urandom_range(0, 1) == 1) begin
        rd_byte(m_byte);
        m_dr = 1'b0; m_ov = 1'b0;
        chk("rnd_rd_dr", data_ready, 0);
      end
    end

    // reset mid TX and mid RX frame with a full holding register
    rx_send(8'h44, 1'b1, 0);
    repeat (3) @(negedge clk);
    wr_byte(8'hC3);
    wait_tbre();
    wr_byte(8'h7E);
    rxd = 1'b0;
    repeat (25) @(negedge clk);
    chk("pre_rst_tsre", tsre, 0);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_tbre", tbre, 1);
    chk("mid_rst_tsre", tsre, 1);
    chk("mid_rst_dr", data_ready, 0);
    chk("mid_rst_ov", overrun, 0);
    chk("mid_rst_oe", bus_data_oe, 0);
    chk("mid_rst_data", bus_data_o, 0);
    idle_tx("rst_drops_hold");
    fork
      wr_byte(8'h81);
      tx_mon(8'h81, 20);
    join
    rx_send(8'h96, 1'b1, 0);
    repeat (3) @(negedge clk);
    chk("post_rst_dr", data_ready, 1);
    rd_byte(8'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
